// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts a parallel word over a valid/ready handshake
// and shifts it out as start bit, LSB-first data, optional parity and stop bits,
// one bit per baud_tick interval.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int   CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic ODD_SEL  = (PARITY_ODD != 0);
    localparam logic HAS_PAR  = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 parity_bit;
    logic                 data_last;
    logic                 stop_last;

    // bit_cnt counts data bits already on the line while in DATA, and
    // completed stop-bit intervals while in STOP.
    assign data_last = (bit_cnt == CNT_W'(DATA_BITS));
    assign stop_last = (bit_cnt == CNT_W'(STOP_BITS - 1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a tick coincident with acceptance is not seen because
    // acceptance happens in IDLE, which ignores baud_tick.
    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tx_valid)  state_nxt = ARM;
            ARM:     if (baud_tick) state_nxt = START;
            START:   if (baud_tick) state_nxt = DATA;
            DATA: begin
                if (baud_tick && data_last) begin
                    state_nxt = HAS_PAR ? PARITY : STOP;
                end
            end
            PARITY:  if (baud_tick) state_nxt = STOP;
            STOP:    if (baud_tick && stop_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        tx_ready = (state == IDLE);
        tx_busy  = (state != IDLE);
    end

    // Datapath: line register, shift register, bit counter and done pulse.
    // All line changes happen only on edges that consume a baud_tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx         <= 1'b1;
            tx_done    <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_valid) begin
                        shift_reg  <= tx_data;
                        parity_bit <= (^tx_data) ^ ODD_SEL;
                        bit_cnt    <= '0;
                    end
                end
                ARM: begin
                    if (baud_tick) begin
                        tx <= 1'b0;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (data_last) begin
                            tx      <= HAS_PAR ? parity_bit : 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (stop_last) begin
                            tx_done <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four configurations share one stimulus
// bus; each scenario resets all of them and follows one configuration's line.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] div = 2'd0;
    logic       baud_tick;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [3:0] tx_v, ready_v, busy_v, done_v;

    int checks = 0;
    int errors = 0;

    localparam int D8N1 = 0;
    localparam int D8E1 = 1;
    localparam int D8O1 = 2;
    localparam int D8N2 = 3;

    always #5 clk = ~clk;

    // Baud tick every 4 clocks.
    always @(posedge clk) div <= div + 2'd1;
    assign baud_tick = (div == 2'd3);

    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_e1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_o1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_n2 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

    task automatic apply_reset();
        @(negedge clk);
        tx_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait for the next edge consuming a baud_tick; meanwhile every sampled
    // cycle must show the held line value, busy, and no done pulse.
    task automatic wait_tick(input int sel, input logic exp_tx, output int bad, output bit ok);
        int c;
        bad = 0;
        ok  = 1'b0;
        c   = 0;
        while (!ok && c < 32) begin
            @(negedge clk);
            if (tx_v[sel] !== exp_tx || done_v[sel] !== 1'b0 || ready_v[sel] !== 1'b0) bad++;
            if (baud_tick) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
            c++;
        end
    endtask

    // Offer a word away from a tick; returns 1 clock after the accepting edge.
    task automatic send(input int sel, input logic [7:0] data, input bit hold);
        int c = 0;
        while (!baud_tick && c < 8) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        tx_data  = data;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
        checks++;
        if (ready_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1) begin
            errors++;
            $display("FAIL accept_%h ready=%b busy=%b required ready=0 busy=1", data, ready_v[sel], busy_v[sel]);
        end
    endtask

    // Follow a frame from just after acceptance: bits[k] is the k-th bit on the line.
    task automatic check_frame(input int sel, input logic [15:0] bits, input int n,
                               input string name, input bit hold);
        int   bad;
        bit   ok;
        logic exp_tx = 1'b1;
        for (int k = 0; k <= n; k++) begin
            wait_tick(sel, exp_tx, bad, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s tick_timeout at bit %0d", name, k);
                return;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s interval_before_bit_%0d bad_cycles=%0d required 0 (held tx=%b)", name, k, bad, exp_tx);
            end
            if (k < n) begin
                checks++;
                if (tx_v[sel] !== bits[k]) begin
                    errors++;
                    $display("FAIL %s bit_%0d tx=%b required %b", name, k, tx_v[sel], bits[k]);
                end
                exp_tx = bits[k];
            end else begin
                checks++;
                if (done_v[sel] !== 1'b1 || ready_v[sel] !== 1'b1 || tx_v[sel] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s end done=%b ready=%b tx=%b required 1 1 1", name, done_v[sel], ready_v[sel], tx_v[sel]);
                end
            end
        end
        if (!hold) tx_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (done_v[sel] !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width done=%b required 0", name, done_v[sel]);
        end
    endtask

    task automatic test_reset();
        #12;
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (tx_v[s] !== 1'b1 || ready_v[s] !== 1'b1 || busy_v[s] !== 1'b0 || done_v[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_dut%0d tx=%b ready=%b busy=%b done=%b required 1 1 0 0",
                         s, tx_v[s], ready_v[s], busy_v[s], done_v[s]);
            end
        end
        apply_reset();
        // Ticks while idle must leave the line high and the block ready.
        repeat (10) @(negedge clk);
        checks++;
        if (tx_v[0] !== 1'b1 || ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_ticks tx=%b ready=%b busy=%b required 1 1 0", tx_v[0], ready_v[0], busy_v[0]);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        send(D8N1, 8'hA5, 1'b0);
        check_frame(D8N1, 16'({1'b1, 8'hA5, 1'b0}), 10, "n1_a5", 1'b0);
    endtask

    task automatic test_parity();
        apply_reset();
        send(D8E1, 8'hA5, 1'b0);
        check_frame(D8E1, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, "even_a5", 1'b0);
        apply_reset();
        send(D8O1, 8'hA5, 1'b0);
        check_frame(D8O1, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, "odd_a5", 1'b0);
        apply_reset();
        send(D8E1, 8'h01, 1'b0);
        check_frame(D8E1, 16'({1'b1, 1'b1, 8'h01, 1'b0}), 11, "even_01", 1'b0);
    endtask

    task automatic test_two_stop();
        apply_reset();
        send(D8N2, 8'h00, 1'b0);
        check_frame(D8N2, 16'({2'b11, 8'h00, 1'b0}), 11, "stop2_00", 1'b0);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send(D8N1, 8'h55, 1'b1);
        // New data while busy must not disturb frame 1; it becomes frame 2.
        tx_data = 8'h33;
        check_frame(D8N1, 16'({1'b1, 8'h55, 1'b0}), 10, "b2b_55", 1'b1);
        checks++;
        if (busy_v[D8N1] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reaccept busy=%b required 1", busy_v[D8N1]);
        end
        check_frame(D8N1, 16'({1'b1, 8'h33, 1'b0}), 10, "b2b_33", 1'b0);
    endtask

    task automatic test_accept_on_tick();
        int c = 0;
        apply_reset();
        while (!baud_tick && c < 8) begin
            @(negedge clk);
            c++;
        end
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        checks++;
        if (tx_v[D8N1] !== 1'b1 || busy_v[D8N1] !== 1'b1) begin
            errors++;
            $display("FAIL coincident_accept tx=%b busy=%b required 1 1", tx_v[D8N1], busy_v[D8N1]);
        end
        check_frame(D8N1, 16'({1'b1, 8'h96, 1'b0}), 10, "coincident_96", 1'b0);
    endtask

    task automatic test_mid_frame_reset();
        int   bad;
        bit   ok;
        logic exp_tx = 1'b1;
        apply_reset();
        send(D8N1, 8'hF0, 1'b0);
        // Start bit then data bits 0..3 of 0xF0: all zero on the line.
        for (int k = 0; k < 5; k++) begin
            wait_tick(D8N1, exp_tx, bad, ok);
            checks++;
            if (!ok || bad != 0 || tx_v[D8N1] !== 1'b0) begin
                errors++;
                $display("FAIL pre_reset_bit_%0d ok=%b bad=%0d tx=%b required 1 0 0", k, ok, bad, tx_v[D8N1]);
            end
            exp_tx = 1'b0;
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_v[D8N1] !== 1'b1 || busy_v[D8N1] !== 1'b0 || ready_v[D8N1] !== 1'b1 || done_v[D8N1] !== 1'b0) begin
            errors++;
            $display("FAIL async_abort tx=%b busy=%b ready=%b done=%b required 1 0 1 0",
                     tx_v[D8N1], busy_v[D8N1], ready_v[D8N1], done_v[D8N1]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[D8N1] !== 1'b0 || tx_v[D8N1] !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_abort_idle bad_cycles=%0d required 0", bad);
        end
        send(D8N1, 8'hC3, 1'b0);
        check_frame(D8N1, 16'({1'b1, 8'hC3, 1'b0}), 10, "after_reset_c3", 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_accept_on_tick();
        test_mid_frame_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
